// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and write-port priority helper for regfile_mp.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 8;
   localparam int NR_DEF    = 6;
   localparam int NW_DEF    = 4;

   // Priority search is sized for up to 32 write ports.
   localparam int c_nw_max  = 32;
   localparam int c_pw      = 5;

   typedef struct packed {
      logic              hit;
      logic [c_pw-1:0]   idx;
   } wsel_t;

   // Highest-index asserted match wins.
   function automatic wsel_t wsel_win(input logic [c_nw_max-1:0] match);
      wsel_t r;
      r.hit = 1'b0;
      r.idx = '0;
      for (int j = 0; j < c_nw_max; j++) begin
         if (match[j]) begin
            r.hit = 1'b1;
            r.idx = c_pw'(j);
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wsel.sv
// ============================================================================
// Module      : regfile_wsel
// Description : Priority selector over NW write ports for one address.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wsel
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = 3,
   parameter int NW = NW_DEF
) (
   input  logic [AW-1:0]    i_addr,
   input  logic [NW-1:0]    i_wen,
   input  logic [NW*AW-1:0] i_waddr,
   input  logic [NW*DW-1:0] i_wdata,
   output logic             o_hit,
   output logic [DW-1:0]    o_data
);

   logic [c_nw_max-1:0] w_match;
   wsel_t               w_win;

   always_comb begin
      w_match = '0;
      for (int j = 0; j < NW; j++) begin
         w_match[j] = i_wen[j] && (i_waddr[j*AW +: AW] == i_addr);
      end
      w_win  = wsel_win(w_match);
      o_data = '0;
      for (int j = 0; j < NW; j++) begin
         if (w_win.hit && (w_win.idx == c_pw'(j))) begin
            o_data = i_wdata[j*DW +: DW];
         end
      end
   end

   assign o_hit = w_win.hit;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file with registered reads and busy
//               scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH),
   parameter int NR    = NR_DEF,
   parameter int NW    = NW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NR*AW-1:0]  raddr,
   output logic [NR*DW-1:0]  rdata,
   output logic [NR-1:0]     rbusy,
   input  logic [NW-1:0]     wen,
   input  logic [NW*AW-1:0]  waddr,
   input  logic [NW*DW-1:0]  wdata,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   output logic [DEPTH-1:0]  busy
);

   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [NR*DW-1:0] r_rdata;
   logic [NR-1:0]    r_rbusy;

   logic [DEPTH-1:0] w_ent_hit;
   logic [DW-1:0]    w_ent_data [DEPTH];
   logic [DEPTH-1:0] w_busy_nxt;
   logic [NR*DW-1:0] w_rdata_nxt;
   logic [NR-1:0]    w_rbusy_nxt;
   logic             w_rsv_ok;

   assign w_rsv_ok = ({1'b0, rsv_addr} < (AW+1)'(DEPTH));

   // Out-of-range write addresses match no entry and are dropped here.
   generate
      for (genvar e = 0; e < DEPTH; e++) begin : g_ent
         regfile_wsel #(
            .DW (DW),
            .AW (AW),
            .NW (NW)
         ) u_wsel (
            .i_addr  (AW'(e)),
            .i_wen   (wen),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .o_hit   (w_ent_hit[e]),
            .o_data  (w_ent_data[e])
         );
      end
   endgenerate

   // Reserve beats a same-edge write clear.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         w_busy_nxt[e] = r_busy[e];
         if (w_ent_hit[e]) begin
            w_busy_nxt[e] = 1'b0;
         end
         if (rsv_en && w_rsv_ok && (rsv_addr == AW'(e))) begin
            w_busy_nxt[e] = 1'b1;
         end
      end
   end

   generate
      for (genvar i = 0; i < NR; i++) begin : g_rd
         logic [AW-1:0] w_ra;
         logic          w_ok;

         assign w_ra = raddr[i*AW +: AW];
         assign w_ok = ({1'b0, w_ra} < (AW+1)'(DEPTH));

`ifdef REGFILE_BYPASS_EN
         logic          w_fwd_hit;
         logic [DW-1:0] w_fwd_data;

         regfile_wsel #(
            .DW (DW),
            .AW (AW),
            .NW (NW)
         ) u_byp (
            .i_addr  (w_ra),
            .i_wen   (wen),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .o_hit   (w_fwd_hit),
            .o_data  (w_fwd_data)
         );

         assign w_rdata_nxt[i*DW +: DW] = !w_ok     ? '0 :
                                          w_fwd_hit ? w_fwd_data : r_mem[w_ra];
         assign w_rbusy_nxt[i]          = w_ok && w_busy_nxt[w_ra];
`else
         assign w_rdata_nxt[i*DW +: DW] = w_ok ? r_mem[w_ra] : '0;
         assign w_rbusy_nxt[i]          = w_ok && r_busy[w_ra];
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            r_mem[e] <= '0;
         end
         r_busy  <= '0;
         r_rdata <= '0;
         r_rbusy <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (w_ent_hit[e]) begin
               r_mem[e] <= w_ent_data[e];
            end
         end
         r_busy  <= w_busy_nxt;
         r_rdata <= w_rdata_nxt;
         r_rbusy <= w_rbusy_nxt;
      end
   end

   assign rdata = r_rdata;
   assign rbusy = r_rbusy;
   assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (either bypass build).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int NR    = 6;
   localparam int NW    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic [NR-1:0]     rbusy;
   logic [NW-1:0]     wen;
   logic [NW*AW-1:0]  waddr;
   logic [NW*DW-1:0]  wdata;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;
   logic [DEPTH-1:0]  busy;

   int n_err = 0;
   int n_chk = 0;

   regfile_mp #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .NR    (NR),
      .NW    (NW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen    = '0;
      rsv_en = 1'b0;
   endtask

   task automatic wr(input int port, input int addr, input int data);
      wen[port]                = 1'b1;
      waddr[port*AW +: AW]     = AW'(addr);
      wdata[port*DW +: DW]     = DW'(data);
   endtask

   task automatic rd(input int port, input int addr);
      raddr[port*AW +: AW] = AW'(addr);
   endtask

   function automatic logic [DW-1:0] rd_of(input int port);
      return rdata[port*DW +: DW];
   endfunction

   initial begin
      reset    = 1'b1;
      raddr    = '0;
      wen      = '0;
      waddr    = '0;
      wdata    = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      tick();
      reset = 1'b0;
      chk("reset_busy", 32'(busy), 32'h00);
      chk("reset_rbusy", 32'(rbusy), 32'h00);

      // Sweep all eight addresses across the six read ports.
      for (int b = 0; b < 8; b += 6) begin
         for (int i = 0; i < NR; i++) rd(i, (b + i) % 8);
         tick();
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("rst_rd_a%0d", (b + i) % 8), 32'(rd_of(i)), 32'h00);
            chk($sformatf("rst_rb_a%0d", (b + i) % 8), 32'(rbusy[i]), 32'h0);
         end
      end

      // Simple write then read on another port.
      wr(0, 3, 8'hA5);
      tick();
      idle();
      rd(5, 3);
      tick();
      chk("wr_a3_p5", 32'(rd_of(5)), 32'hA5);
      chk("wr_a3_rb", 32'(rbusy[5]), 32'h0);

      // Conflict: port 3 beats port 1.
      wr(1, 2, 8'h11);
      wr(3, 2, 8'h33);
      tick();
      idle();
      rd(0, 2);
      tick();
      chk("prio_a2", 32'(rd_of(0)), 32'h33);

      // Conflict: port 3 beats port 0 regardless of the port order driven.
      wr(3, 1, 8'h44);
      wr(0, 1, 8'h55);
      tick();
      idle();
      rd(0, 1);
      tick();
      chk("prio_a1", 32'(rd_of(0)), 32'h44);

      // Scoreboard: reserve, then write+reserve, then write only.
      rsv_en   = 1'b1;
      rsv_addr = 3'd4;
      tick();
      chk("rsv_busy", 32'(busy), 32'h10);
      wr(2, 4, 8'h7E);
      rd(1, 4);
      tick();
      chk("rsv_win_busy", 32'(busy), 32'h10);
      chk("rsv_win_rbusy", 32'(rbusy[1]), 32'h1);
      rsv_en = 1'b0;
      tick();
      chk("wr_clr_busy", 32'(busy), 32'h00);
`ifdef REGFILE_BYPASS_EN
      chk("wr_clr_rbusy", 32'(rbusy[1]), 32'h0);
`else
      chk("wr_clr_rbusy", 32'(rbusy[1]), 32'h1);
`endif
      chk("wr_clr_rdata", 32'(rd_of(1)), 32'h7E);
      idle();
      tick();
      chk("a4_rdata", 32'(rd_of(1)), 32'h7E);
      chk("a4_rbusy", 32'(rbusy[1]), 32'h0);

      // Same-cycle read/write of address 6.
      wr(0, 6, 8'hC3);
      rd(2, 6);
      tick();
`ifdef REGFILE_BYPASS_EN
      chk("same_cyc_a6", 32'(rd_of(2)), 32'hC3);
`else
      chk("same_cyc_a6", 32'(rd_of(2)), 32'h00);
`endif
      idle();
      tick();
      chk("next_cyc_a6", 32'(rd_of(2)), 32'hC3);

      // Reserve one address while clearing another by write.
      rsv_en   = 1'b1;
      rsv_addr = 3'd7;
      wr(3, 0, 8'h99);
      rd(4, 7);
      tick();
      idle();
      chk("rsv7_busy", 32'(busy), 32'h80);
`ifdef REGFILE_BYPASS_EN
      chk("rsv7_rbusy", 32'(rbusy[4]), 32'h1);
`else
      chk("rsv7_rbusy", 32'(rbusy[4]), 32'h0);
`endif
      rd(0, 3); rd(1, 2); rd(2, 4); rd(3, 6); rd(4, 0); rd(5, 7);
      tick();
      chk("pre_rst_p0", 32'(rd_of(0)), 32'hA5);
      chk("pre_rst_p4", 32'(rd_of(4)), 32'h99);
      chk("pre_rst_rb5", 32'(rbusy[5]), 32'h1);

      // Reset mid-stream with writes and a reserve on the same edge.
      wr(0, 0, 8'hF0); wr(1, 1, 8'hF1); wr(2, 5, 8'hF2); wr(3, 6, 8'hF3);
      rsv_en   = 1'b1;
      rsv_addr = 3'd5;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      chk("mid_rst_busy", 32'(busy), 32'h00);
      chk("mid_rst_rdata", 32'(rdata), 32'h0);
      chk("mid_rst_rbusy", 32'(rbusy), 32'h00);
      for (int b = 0; b < 8; b += 6) begin
         for (int i = 0; i < NR; i++) rd(i, (b + i) % 8);
         tick();
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("post_rst_a%0d", (b + i) % 8), 32'(rd_of(i)), 32'h00);
            chk($sformatf("post_rst_rb%0d", (b + i) % 8), 32'(rbusy[i]), 32'h0);
         end
      end
      chk("post_rst_busy", 32'(busy), 32'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
